// File: rtl/pokey_key_scanner.sv
// POKEY keyboard scan controller: walks the key matrix, confirms a key and raises a sticky IRQ.
// Define POKEY_KEY_DEBOUNCE_EN to get two-pass press/release confirmation (SEEN/RELEASE_SEEN).
module pokey_key_scanner #(
   parameter int unsigned SCAN_BITS = 6
) (
   input  logic                 inClk,
   input  logic                 n_reset,
   input  logic                 scanTick,
   input  logic                 scanEnable,
   input  logic                 keyIn,
   input  logic                 kbcodeAck,
   output logic [SCAN_BITS-1:0] scanAddr,
   output logic [SCAN_BITS-1:0] kbcode,
   output logic                 keyIrq,
   output logic                 keyHeld,
   output logic                 overrun
);

`ifdef POKEY_KEY_DEBOUNCE_EN
   typedef enum logic [1:0] {IDLE, SEEN, HELD, RELEASE_SEEN} state_t;
`else
   typedef enum logic {IDLE, HELD} state_t;
`endif

   state_t               state_q, state_d;
   logic [SCAN_BITS-1:0] scanAddr_q, scanAddr_d;
   logic [SCAN_BITS-1:0] cmp_q, cmp_d;
   logic [SCAN_BITS-1:0] kbcode_q, kbcode_d;
   logic                 keyIrq_q, keyIrq_d;
   logic                 keyHeld_q, keyHeld_d;
   logic                 overrun_q, overrun_d;
   logic                 atCmp;
   logic                 accept;
   logic                 release_key;

   assign atCmp = (scanAddr_q == cmp_q);

   always_ff @(posedge inClk) begin
      if (!n_reset) begin
         state_q    <= IDLE;
         scanAddr_q <= '0;
         cmp_q      <= '0;
         kbcode_q   <= '0;
         keyIrq_q   <= 1'b0;
         keyHeld_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         scanAddr_q <= scanAddr_d;
         cmp_q      <= cmp_d;
         kbcode_q   <= kbcode_d;
         keyIrq_q   <= keyIrq_d;
         keyHeld_q  <= keyHeld_d;
         overrun_q  <= overrun_d;
      end
   end

   // Only the tracked address (cmp) is looked at outside IDLE, which gives n-key lockout.
   always_comb begin
      state_d     = state_q;
      cmp_d       = cmp_q;
      accept      = 1'b0;
      release_key = 1'b0;
      if (!scanEnable) begin
         state_d = IDLE;
      end else if (scanTick) begin
         case (state_q)
            IDLE: begin
               if (keyIn) begin
                  cmp_d = scanAddr_q;
`ifdef POKEY_KEY_DEBOUNCE_EN
                  state_d = SEEN;
`else
                  state_d = HELD;
                  accept  = 1'b1;
`endif
               end
            end
`ifdef POKEY_KEY_DEBOUNCE_EN
            SEEN: begin
               if (atCmp) begin
                  if (keyIn) begin
                     state_d = HELD;
                     accept  = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            HELD: begin
               if (atCmp && !keyIn) state_d = RELEASE_SEEN;
            end
            RELEASE_SEEN: begin
               if (atCmp) begin
                  if (keyIn) begin
                     state_d = HELD;
                  end else begin
                     state_d     = IDLE;
                     release_key = 1'b1;
                  end
               end
            end
`else
            HELD: begin
               if (atCmp && !keyIn) begin
                  state_d     = IDLE;
                  release_key = 1'b1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   // An accept overrides a same-cycle acknowledge; overrun looks at the pre-edge keyIrq.
   always_comb begin
      scanAddr_d = (scanTick && scanEnable) ? scanAddr_q + SCAN_BITS'(1) : scanAddr_q;
      kbcode_d   = accept ? cmp_d : kbcode_q;
      keyIrq_d   = accept ? 1'b1 : (kbcodeAck ? 1'b0 : keyIrq_q);
      if (accept && keyIrq_q)
         overrun_d = 1'b1;
      else if (kbcodeAck)
         overrun_d = 1'b0;
      else
         overrun_d = overrun_q;
      if (!scanEnable || release_key)
         keyHeld_d = 1'b0;
      else if (accept)
         keyHeld_d = 1'b1;
      else
         keyHeld_d = keyHeld_q;
   end

   assign scanAddr = scanAddr_q;
   assign kbcode   = kbcode_q;
   assign keyIrq   = keyIrq_q;
   assign keyHeld  = keyHeld_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_pokey_key_scanner.sv
// Directed bench for pokey_key_scanner; expectations follow POKEY_KEY_DEBOUNCE_EN when defined.
module tb_pokey_key_scanner;

`ifdef POKEY_KEY_DEBOUNCE_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic       inClk = 1'b0;
   logic       n_reset, scanTick, scanEnable, keyIn, kbcodeAck;
   logic [5:0] scanAddr, kbcode;
   logic       keyIrq, keyHeld, overrun;

   logic [63:0] keys;
   logic [5:0]  addr_m;
   int          n_cmp = 0;
   int          n_err = 0;

   pokey_key_scanner #(.SCAN_BITS(6)) dut (
      .inClk(inClk), .n_reset(n_reset), .scanTick(scanTick), .scanEnable(scanEnable),
      .keyIn(keyIn), .kbcodeAck(kbcodeAck), .scanAddr(scanAddr), .kbcode(kbcode),
      .keyIrq(keyIrq), .keyHeld(keyHeld), .overrun(overrun)
   );

   always #5 inClk = ~inClk;

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // n scan steps; keyIn presents the model key map at the model address; optional ack on last step
   task automatic run(input int n, input bit ack_last);
      for (int i = 0; i < n; i++) begin
         scanTick  = 1'b1;
         keyIn     = keys[addr_m];
         kbcodeAck = ack_last && (i == n - 1);
         @(posedge inClk); #1;
         addr_m++;
      end
      scanTick = 1'b0; keyIn = 1'b0; kbcodeAck = 1'b0;
      chk("scanAddr_track", scanAddr, addr_m);
   endtask

   task automatic lone_ack();
      kbcodeAck = 1'b1;
      @(posedge inClk); #1;
      kbcodeAck = 1'b0;
   endtask

   initial begin
      n_reset = 1'b0; scanTick = 1'b0; scanEnable = 1'b1; keyIn = 1'b0; kbcodeAck = 1'b0;
      keys = '0; addr_m = '0;
      repeat (2) @(posedge inClk); #1;
      chk("rst_scanAddr", scanAddr, 6'h00);
      chk("rst_kbcode",   kbcode,   6'h00);
      chk("rst_keyIrq",   keyIrq,   6'h0);
      chk("rst_keyHeld",  keyHeld,  6'h0);
      chk("rst_overrun",  overrun,  6'h0);
      n_reset = 1'b1;

      // empty scan: address walk and wrap
      run(63, 0);
      chk("walk_63", scanAddr, 6'h3f);
      run(1, 0);
      chk("walk_wrap", scanAddr, 6'h00);
      chk("walk_irq", keyIrq, 6'h0);
      chk("walk_kbcode", kbcode, 6'h00);

      // 0x15 present for one scan only
      keys = '0; keys[6'h15] = 1'b1;
      run(22, 0);
      keys = '0;
      run(64, 0);
      chk("glitch_kbcode", kbcode, DB ? 6'h00 : 6'h15);
      chk("glitch_irq", keyIrq, DB ? 6'h0 : 6'h1);
      chk("glitch_held", keyHeld, 6'h0);
      lone_ack();
      chk("ack_irq", keyIrq, 6'h0);
      chk("ack_ovr", overrun, 6'h0);

      // steady 0x15: accept one full scan after first sight
      keys[6'h15] = 1'b1;
      run(64, 0);
      chk("sight_irq", keyIrq, DB ? 6'h0 : 6'h1);
      run(63, 0);
      chk("pre_accept_irq", keyIrq, DB ? 6'h0 : 6'h1);
      run(1, 0);
      chk("acc15_kbcode", kbcode, 6'h15);
      chk("acc15_irq", keyIrq, 6'h1);
      chk("acc15_held", keyHeld, 6'h1);
      chk("acc15_ovr", overrun, 6'h0);

      // lockout of 0x22 while 0x15 held, then release 0x15
      keys[6'h22] = 1'b1;
      run(64, 0);
      chk("lock_kbcode", kbcode, 6'h15);
      chk("lock_held", keyHeld, 6'h1);
      keys[6'h15] = 1'b0;
      run(64, 0);
      chk("rel1_held", keyHeld, DB ? 6'h1 : 6'h0);
      run(64, 0);
      chk("rel2_held", keyHeld, DB ? 6'h0 : 6'h1);
      chk("rel2_kbcode", kbcode, DB ? 6'h15 : 6'h22);
      run(128, 0);
      chk("acc22_kbcode", kbcode, 6'h22);
      chk("acc22_irq", keyIrq, 6'h1);
      chk("acc22_ovr", overrun, 6'h1);
      chk("acc22_held", keyHeld, 6'h1);

      // release 0x22, then accept 0x07 on the same edge as an ack
      keys = '0;
      run(128, 0);
      chk("rel22_held", keyHeld, 6'h0);
      keys[6'h07] = 1'b1;
      run(49, 0);
      if (DB) run(64, 0);
      run(1, 1);
      chk("ackacc_kbcode", kbcode, 6'h07);
      chk("ackacc_irq", keyIrq, 6'h1);
      chk("ackacc_ovr", overrun, 6'h1);
      lone_ack();
      chk("ack2_irq", keyIrq, 6'h0);
      chk("ack2_ovr", overrun, 6'h0);

      // scanEnable=0 during confirmation of 0x30
      keys = '0;
      run(128, 0);
      keys[6'h30] = 1'b1;
      run(41, 0);
      run(63, 0);
      chk("pre_dis_addr", scanAddr, 6'h30);
      chk("pre_dis_held", keyHeld, DB ? 6'h0 : 6'h1);
      scanEnable = 1'b0; scanTick = 1'b1; keyIn = 1'b1;
      @(posedge inClk); #1;
      scanTick = 1'b0; keyIn = 1'b0; scanEnable = 1'b1;
      chk("dis_addr", scanAddr, 6'h30);
      chk("dis_held", keyHeld, 6'h0);
      chk("dis_kbcode", kbcode, DB ? 6'h07 : 6'h30);
      chk("dis_irq", keyIrq, DB ? 6'h0 : 6'h1);
      run(1, 0);
      chk("reen_irq", keyIrq, DB ? 6'h0 : 6'h1);
      chk("reen_held", keyHeld, DB ? 6'h0 : 6'h1);
      chk("reen_ovr", overrun, DB ? 6'h0 : 6'h1);

      // reset while held
      run(64, 0);
      chk("held30_held", keyHeld, 6'h1);
      chk("held30_irq", keyIrq, 6'h1);
      n_reset = 1'b0; scanTick = 1'b1; keyIn = 1'b1;
      @(posedge inClk); #1;
      n_reset = 1'b1; scanTick = 1'b0; keyIn = 1'b0;
      addr_m = '0;
      chk("mrst_scanAddr", scanAddr, 6'h00);
      chk("mrst_kbcode",   kbcode,   6'h00);
      chk("mrst_keyIrq",   keyIrq,   6'h0);
      chk("mrst_keyHeld",  keyHeld,  6'h0);
      chk("mrst_overrun",  overrun,  6'h0);
      run(49, 0);
      chk("post_rst_irq", keyIrq, DB ? 6'h0 : 6'h1);
      chk("post_rst_kbcode", kbcode, DB ? 6'h00 : 6'h30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
